// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// State encoding, keypad geometry and calculator key codes.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } state_e;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;
  localparam int KEY_W  = 4;

  // code = row*4 + col
  localparam logic [KEY_W-1:0] KEY_1   = 4'd0;
  localparam logic [KEY_W-1:0] KEY_2   = 4'd1;
  localparam logic [KEY_W-1:0] KEY_3   = 4'd2;
  localparam logic [KEY_W-1:0] KEY_ADD = 4'd3;
  localparam logic [KEY_W-1:0] KEY_4   = 4'd4;
  localparam logic [KEY_W-1:0] KEY_5   = 4'd5;
  localparam logic [KEY_W-1:0] KEY_6   = 4'd6;
  localparam logic [KEY_W-1:0] KEY_SUB = 4'd7;
  localparam logic [KEY_W-1:0] KEY_7   = 4'd8;
  localparam logic [KEY_W-1:0] KEY_8   = 4'd9;
  localparam logic [KEY_W-1:0] KEY_9   = 4'd10;
  localparam logic [KEY_W-1:0] KEY_MUL = 4'd11;
  localparam logic [KEY_W-1:0] KEY_CLR = 4'd12;
  localparam logic [KEY_W-1:0] KEY_0   = 4'd13;
  localparam logic [KEY_W-1:0] KEY_EQ  = 4'd14;
  localparam logic [KEY_W-1:0] KEY_DIV = 4'd15;

  // index of the lowest active-low row
  function automatic logic [1:0] low_row(
    input logic [N_ROWS-1:0] rows
  );
    logic [1:0] r;
    r = 2'd0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous key event FIFO, no bypass; full push+pop both succeed.
// Ports: clk, rst (sync, active-low), push/din/full, pop/dout/empty.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign dout  = empty ? '0 : mem_q[rd_q];

  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop_ok ? rd_q + AW'(1) : rd_q;
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner sharing one debounce counter across all keys.
// Ports: clk, rst (sync, active-low), row_in, col_out, key_valid/key_code/key_ready, overflow.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_CYCLES = 1500000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  input  logic             key_ready,
  output logic             overflow
);

  localparam int MAXC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ?
                        SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  cand_row_q, cand_row_d;
  logic [3:0]  col_out_q, col_out_d;
  logic        overflow_q, overflow_d;
  logic [3:0]  sync1_q, rows_q;
  logic        push, full, empty;

  assign col_out   = col_out_q;
  assign overflow  = overflow_q;
  assign key_valid = !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= SCAN;
      cnt_q      <= '0;
      col_q      <= 2'd0;
      cand_row_q <= 2'd0;
      col_out_q  <= 4'b1110;
      overflow_q <= 1'b0;
      sync1_q    <= 4'b1111;
      rows_q     <= 4'b1111;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      cand_row_q <= cand_row_d;
      col_out_q  <= col_out_d;
      overflow_q <= overflow_d;
      sync1_q    <= row_in;
      rows_q     <= sync1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    col_d      = col_q;
    cand_row_d = cand_row_q;
    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (rows_q != 4'hF) begin
            state_d    = DEBOUNCE;
            cand_row_d = low_row(rows_q);
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        // a bounce abandons the candidate and moves on
        if (rows_q[cand_row_q]) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (rows_q != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    push = (state_q == DEBOUNCE) && !rows_q[cand_row_q]
           && (cnt_q == DEB_LAST);
    // a same-cycle pop frees a slot, so no drop
    overflow_d = push && full && !key_ready;
    col_out_d  = ~(4'b0001 << col_d);
  end

  key_fifo #(
    .WIDTH(KEY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  ({cand_row_q, col_q}),
    .full (full),
    .pop  (key_ready),
    .dout (key_code),
    .empty(empty)
  );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a simple 4x4 switch-matrix model.
// Short scan/debounce times keep every scenario to a few hundred cycles.
module tb_keypad_scan_ctrl;

  localparam int SC = 4;
  localparam int DC = 16;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic        overflow;
  logic [15:0] keys = '0;

  int checks  = 0;
  int errors  = 0;
  int ovf_cnt = 0;
  int n;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_CYCLES(DC),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .overflow (overflow)
  );

  // switch matrix: a closed key pulls its row low while its column is driven
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // wait for a fresh entry into the column whose drive pattern is exp
  task automatic wait_enter(input string tag, input logic [3:0] exp,
                            output int cnt);
    cnt = 0;
    while (col_out === exp && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    while (col_out !== exp && cnt < 80) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, col_out, exp);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] exp,
                          input int max, output int cnt);
    cnt = 0;
    while (col_out !== exp && cnt < max) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, col_out, exp);
  endtask

  task automatic wait_valid(input string tag, input int max,
                            output int cnt);
    cnt = 0;
    while (key_valid !== 1'b1 && cnt < max) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, key_valid, 1);
  endtask

  task automatic press(input logic [3:0] code, input int hold);
    logic [3:0] cm;
    int w;
    cm = ~(4'b0001 << code[1:0]);
    wait_enter("press_col", cm, w);
    keys[code] = 1'b1;
    repeat (hold) @(negedge clk);
    keys[code] = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic drain(input string tag, input logic [3:0] e0,
                       input logic [3:0] e1, input logic [3:0] e2,
                       input logic [3:0] e3);
    logic [3:0] exp [4];
    exp = '{e0, e1, e2, e3};
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, key_valid, 1);
      chk({tag, "_code"}, key_code, exp[i]);
      @(negedge clk);
    end
    key_ready = 1'b0;
    chk({tag, "_empty"}, key_valid, 0);
  endtask

  logic [3:0] idle_exp [5];

  initial begin
    idle_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // reset and idle scanning
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_col", col_out, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_ovf", overflow, 0);
    for (int i = 1; i < 5; i++) begin
      repeat (4) @(negedge clk);
      chk("idle_col", col_out, idle_exp[i]);
      chk("idle_valid", key_valid, 0);
    end

    // clean press row 2 / col 1 -> code 9
    wait_enter("p9_col", 4'b1101, n);
    keys[9] = 1'b1;
    wait_valid("p9_valid", 40, n);
    chk("p9_lat", n, 20);
    chk("p9_code", key_code, 9);
    repeat (20) @(negedge clk);
    chk("p9_hold_col", col_out, 4'b1101);
    keys[9] = 1'b0;
    wait_col("p9_next_col", 4'b1011, 40, n);
    chk("p9_rel_lat", n, 18);
    chk("p9_code2", key_code, 9);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    chk("p9_single", key_valid, 0);

    // bounce during debounce on row 0 / col 3
    wait_enter("b3_col", 4'b0111, n);
    keys[3] = 1'b1;
    repeat (14) @(negedge clk);
    chk("b3_held_col", col_out, 4'b0111);
    keys[3] = 1'b0;
    wait_col("b3_next_col", 4'b1110, 10, n);
    chk("b3_lat", n, 3);
    chk("b3_valid", key_valid, 0);
    chk("b3_ovf", ovf_cnt, 0);

    // five presses with the consumer stalled
    press(4'd5, 24);
    press(4'd14, 24);
    press(4'd0, 24);
    press(4'd7, 24);
    chk("fill_ovf0", ovf_cnt, 0);
    press(4'd10, 24);
    chk("fill_ovf1", ovf_cnt, 1);
    drain("d1", 4'd5, 4'd14, 4'd0, 4'd7);
    chk("d1_ovf", ovf_cnt, 1);

    // push into a full FIFO in the same cycle as a pop
    press(4'd12, 24);
    press(4'd1, 24);
    press(4'd6, 24);
    press(4'd15, 24);
    wait_enter("sim_col", 4'b1110, n);
    keys[8] = 1'b1;
    repeat (19) @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    repeat (4) @(negedge clk);
    keys[8] = 1'b0;
    repeat (24) @(negedge clk);
    chk("sim_ovf", ovf_cnt, 1);
    drain("d2", 4'd1, 4'd6, 4'd15, 4'd8);

    // reset during debounce with two events buffered
    press(4'd2, 24);
    press(4'd13, 24);
    wait_enter("r6_col", 4'b1011, n);
    keys[6] = 1'b1;
    repeat (10) @(negedge clk);
    chk("r6_buf", key_valid, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("r6_col_rst", col_out, 4'b1110);
    chk("r6_valid_rst", key_valid, 0);
    chk("r6_code_rst", key_code, 0);
    chk("r6_ovf_rst", overflow, 0);
    wait_valid("r6_redetect", 100, n);
    chk("r6_code", key_code, 6);
    keys[6] = 1'b0;
    repeat (24) @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    chk("r6_single", key_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
